neural_float_to_fixed: RTL and testbench
========================================

Name: neural_float_to_fixed

Overview:
- Streaming converter from the team's float_24_8 format to signed two's-complement fixed point.
- It is the inverse of the float adder's normalise/round back-end.
- It sits at the datapath output, or wherever neuron results leave the float domain (e.g. for quantised storage or integer post-processing).
- Two-stage pipeline, valid/ready handshake on both sides, saturating, round-half-even.

Parameters:
- FIX_W, 32, total output width in bits (signed).
- FRAC_W, 16, number of fractional bits in the output; must satisfy 0 <= FRAC_W < FIX_W.
- EXP_BIAS, 127, exponent bias: value = (-1)^sgn * 1.man * 2^(exp - EXP_BIAS).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_data  in  float_24_8  input operand (sgn, exp[7:0], man[22:0]).
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  FIX_W  signed fixed-point result.
- out_sat  out  1  result was saturated; aligned with out_data.
- out_valid  out  1  out_data and out_sat are valid.
- out_ready  in  1  downstream accepts this cycle.

Behaviour:
- Reset: already decided — reset is synchronous and active-high, clock is clk. On reset, s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_sat=0.
- Reset mid-stream discards all in-flight data. in_ready=1 in the first cycle after reset deasserts.
- Transfer rule: a transfer occurs when valid && ready on the same rising edge. Data and valid are held stable while valid=1 && ready=0.
- Pipeline enables:
  - en2 = !s2_valid || out_ready
  - en1 = !s1_valid || en2
  - in_ready = en1. This is a combinational path from out_ready, which is permitted.
- Throughput: 1 sample/cycle. Latency is 2 cycles (accept at edge N, out_valid at N+2) when out_ready=1.
- Stage 1 (registered):
  - zero_flag = (exp == 0): flush to zero, sign ignored, out_data=0, out_sat=0.
  - mag = {1'b1, man} (24 bits).
  - shift s = exp - EXP_BIAS + FRAC_W - 23, computed as a signed 10-bit value.
  - sgn is registered.
- Stage 2 (registered):
  - s >= 0: left-shift mag by s. Overflow when the shifted magnitude exceeds 2^(FIX_W-1)-1 for positive inputs, or 2^(FIX_W-1) for negative inputs. Any s >= FIX_W always overflows.
  - s < 0: right-shift mag by -s with round-half-even.
    - guard = first dropped bit; sticky = OR of the remaining dropped bits.
    - Increment when guard && (sticky || lsb).
    - If -s > 24, the result is 0, and no rounding increment is applied.
  - Rounding carry can itself cause overflow; recheck after rounding.
  - Negate the magnitude when sgn=1.
  - On overflow, out_data = sgn ? -2^(FIX_W-1) : 2^(FIX_W-1)-1, and out_sat=1.
  - Negative magnitude exactly 2^(FIX_W-1) is representable: out_sat=0.
- Negative zero from rounding (e.g. -0.25 LSB) produces out_data=0.
- Special encodings: exp=255 is treated as an ordinary exponent (no Inf/NaN semantics); it saturates for the default parameters.
- Ordering: strictly in-order, no drops, no duplicates under any out_ready pattern.

Decomposition:
- The float_24_8 typedef stays in the shared types package.
- Add to the same package:
  - FLOAT_MAN_W=23 and FLOAT_EXP_W=8 constants.
  - A helper function for the round-half-even increment, shared with the adder.
- One sub-module: neural_fixed_round_shift.
  - Inputs: mag, signed shift, sgn.
  - Outputs: rounded signed result, sat.
  - Purely combinational; instantiated in stage 2.

Test Plan (FIX_W=32, FRAC_W=16, EXP_BIAS=127, out_ready=1 unless stated):
- 1.0 (sgn0, exp127, man0) at edge N -> out_data=0x00010000, out_sat=0, out_valid at N+2 only.
- -2.5 (sgn1, exp128, man 0x200000) -> out_data=0xFFFD8000, out_sat=0. exp=0 with any man/sgn -> out_data=0.
- Overflow and saturation:
  - +2^15 (sgn0, exp142, man0) -> out_data=0x7FFFFFFF, out_sat=1.
  - -2^15 -> out_data=0x80000000, out_sat=0.
  - sgn0, exp200 -> out_data=0x7FFFFFFF, out_sat=1.
- Rounding:
  - exp110, man 0x400000 (0.75 LSB) -> out_data=1.
  - exp110, man0 (0.5 LSB) -> out_data=0 (tie to even).
  - exp111, man 0x400000 (1.5 LSB) -> out_data=2.
  - exp90 -> out_data=0.
- Backpressure:
  - Stream 6 samples back-to-back with out_ready low for cycles 3-6 -> in_ready falls once both stages hold data.
  - All 6 results emerge in order, unmodified.
  - out_data is stable while out_valid && !out_ready.
- Reset mid-stream: assert reset for 1 cycle with 2 samples in flight -> out_valid=0 next cycle, in-flight samples never appear, a new sample after reset gets 2-cycle latency.

Source files
------------

// File: rtl/neural_float_to_fixed_pkg.sv
// Shared float_24_8 types and rounding helpers for the neural float datapath.
package neural_float_to_fixed_pkg;

  localparam int FLOAT_MAN_W = 23;
  localparam int FLOAT_EXP_W = 8;

  typedef struct packed {
    logic                   sgn;
    logic [FLOAT_EXP_W-1:0] exp;
    logic [FLOAT_MAN_W-1:0] man;
  } float_24_8;

  // Round-half-even: bump when above half, or exactly half with an odd lsb.
  function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/neural_fixed_round_shift.sv
// Aligns a 24-bit float magnitude to fixed point with round-half-even and saturation.
module neural_fixed_round_shift
  import neural_float_to_fixed_pkg::*;
#(
  parameter int FIX_W = 32
) (
  input  logic [FLOAT_MAN_W:0] mag,
  input  logic signed [9:0]    shift,
  input  logic                 sgn,
  output logic [FIX_W-1:0]     result,
  output logic                 sat
);

  localparam int W = FIX_W + FLOAT_MAN_W + 2;

  logic [W-1:0]         amount;
  logic [W-1:0]         limit;
  logic [9:0]           rsh;
  logic [FLOAT_MAN_W:0] kept;
  logic [FLOAT_MAN_W:0] dropped_mask;
  logic                 guard;
  logic                 sticky;
  logic [FIX_W-1:0]     mag_out;

  always_comb begin
    amount       = '0;
    rsh          = '0;
    kept         = '0;
    dropped_mask = '0;
    guard        = 1'b0;
    sticky       = 1'b0;
    limit        = (W'(1) << (FIX_W - 1)) - W'(!sgn);
    if (!shift[9]) begin
      // All-ones is a sentinel that always compares above the limit.
      if (int'(shift) >= FIX_W) amount = '1;
      else                      amount = W'(mag) << shift[8:0];
    end else begin
      rsh = 10'(-shift);
      if (rsh <= 10'(FLOAT_MAN_W + 1)) begin
        kept         = mag >> rsh;
        dropped_mask = ~({(FLOAT_MAN_W+1){1'b1}} << rsh);
        guard        = |(mag & (dropped_mask ^ (dropped_mask >> 1)));
        sticky       = |(mag & (dropped_mask >> 1));
        amount       = W'(kept) + W'(rne_inc(kept[0], guard, sticky));
      end
    end
    sat     = amount > limit;
    mag_out = amount[FIX_W-1:0];
    if (sat) result = sgn ? {1'b1, {(FIX_W-1){1'b0}}} : {1'b0, {(FIX_W-1){1'b1}}};
    else     result = sgn ? -mag_out : mag_out;
  end

endmodule

// File: rtl/neural_float_to_fixed.sv
// Two-stage streaming float_24_8 to signed fixed-point converter with valid/ready.
module neural_float_to_fixed
  import neural_float_to_fixed_pkg::*;
#(
  parameter int FIX_W    = 32,
  parameter int FRAC_W   = 16,
  parameter int EXP_BIAS = 127
) (
  input  logic             clk,
  input  logic             reset,
  input  float_24_8        in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [FIX_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SHIFT_OFF = FRAC_W - FLOAT_MAN_W - EXP_BIAS;

  logic                   s1_valid;
  logic                   s2_valid;
  logic                   en1;
  logic                   en2;
  logic                   s1_zero;
  logic                   s1_sgn;
  logic [FLOAT_MAN_W:0]   s1_mag;
  logic signed [9:0]      s1_shift;
  logic [FIX_W-1:0]       rs_result;
  logic                   rs_sat;

  assign en2       = !s2_valid || out_ready;
  assign en1       = !s1_valid || en2;
  assign in_ready  = en1;
  assign out_valid = s2_valid;

  neural_fixed_round_shift #(
    .FIX_W (FIX_W)
  ) u_round_shift (
    .mag    (s1_mag),
    .shift  (s1_shift),
    .sgn    (s1_sgn),
    .result (rs_result),
    .sat    (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_sgn   <= 1'b0;
      s1_mag   <= '0;
      s1_shift <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (en1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_zero  <= (in_data.exp == '0);
          s1_sgn   <= in_data.sgn;
          s1_mag   <= {1'b1, in_data.man};
          s1_shift <= $signed({2'b00, in_data.exp}) + 10'(SHIFT_OFF);
        end
      end
      if (en2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          // Zero exponent flushes to +0 regardless of sign.
          out_data <= s1_zero ? '0 : rs_result;
          out_sat  <= !s1_zero && rs_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_neural_float_to_fixed.sv
// Self-checking bench for neural_float_to_fixed: directed table, backpressure, reset, random.
module tb_neural_float_to_fixed;
  import neural_float_to_fixed_pkg::*;

  localparam int FIX_W    = 32;
  localparam int FRAC_W   = 16;
  localparam int EXP_BIAS = 127;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  float_24_8   in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  neural_float_to_fixed #(
    .FIX_W    (FIX_W),
    .FRAC_W   (FRAC_W),
    .EXP_BIAS (EXP_BIAS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q[$];
  logic [32:0] cur_exp = '0;
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
  logic [32:0] prev_word = '0;
  logic        bp_phase = 1'b0, saw_block = 1'b0, rand_bp = 1'b0;

  typedef struct {
    logic [31:0] w;
    logic [31:0] data;
    logic        sat;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: value * 2^FRAC_W computed as mag * 2^e with integer division rounding.
  function automatic logic [32:0] model(input logic [31:0] w);
    logic sgn;
    int e, n;
    longint unsigned mag, v, q, rem, half, lim;
    logic big;
    sgn = w[31];
    if (w[30:23] == 8'd0) return '0;
    mag = {40'd0, 1'b1, w[22:0]};
    e = int'(w[30:23]) - EXP_BIAS + FRAC_W - 23;
    big = 1'b0;
    v = 0;
    if (e >= 0) begin
      if (e >= 40) big = 1'b1;
      else v = mag << e;
    end else begin
      n = -e;
      if (n < 40) begin
        q = mag >> n;
        rem = mag - (q << n);
        half = 64'd1 << (n - 1);
        if (rem > half || (rem == half && q[0])) q++;
        v = q;
      end
    end
    lim = sgn ? (64'd1 << (FIX_W - 1)) : (64'd1 << (FIX_W - 1)) - 1;
    if (big || v > lim) return {1'b1, sgn ? 32'h8000_0000 : 32'h7FFF_FFFF};
    return {1'b0, sgn ? 32'(64'd0 - v) : v[31:0]};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0] ex;
    if ($urandom % 4 == 0) ex = 8'($urandom_range(0, 255));
    else                   ex = 8'($urandom_range(100, 160));
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_v && !prev_r && !prev_rst) begin
        check("hold_valid", 33'(out_valid), 33'(1));
        check("hold_data", {out_sat, out_data}, prev_word);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: actual=%h required=none", {out_sat, out_data});
        end else begin
          check("result", {out_sat, out_data}, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (bp_phase && !in_ready) saw_block = 1'b1;
    end
    prev_v    = out_valid;
    prev_r    = out_ready;
    prev_rst  = reset;
    prev_word = {out_sat, out_data};
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom % 4) != 0;
  end

  task automatic send(input logic [31:0] w, input logic [32:0] e);
    int n;
    in_data  = float_24_8'(w);
    cur_exp  = e;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 33'(in_ready), 33'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain_empty", 33'(exp_q.size()), 33'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic latency_check(input string tag, input logic [31:0] w, input logic [32:0] e);
    in_data   = float_24_8'(w);
    cur_exp   = e;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 33'(in_ready), 33'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid_early"}, 33'(out_valid), 33'(0));
    @(negedge clk);
    check({tag, "_valid_on_time"}, 33'(out_valid), 33'(1));
    check({tag, "_data"}, {out_sat, out_data}, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h3F80_0000, 32'h0001_0000, 1'b0}; // 1.0
    vecs[1]  = '{32'hC020_0000, 32'hFFFD_8000, 1'b0}; // -2.5
    vecs[2]  = '{32'h8012_3456, 32'h0000_0000, 1'b0}; // exp 0, negative
    vecs[3]  = '{32'h007F_FFFF, 32'h0000_0000, 1'b0}; // exp 0
    vecs[4]  = '{32'h4700_0000, 32'h7FFF_FFFF, 1'b1}; // +2^15
    vecs[5]  = '{32'hC700_0000, 32'h8000_0000, 1'b0}; // -2^15
    vecs[6]  = '{32'h6400_0000, 32'h7FFF_FFFF, 1'b1}; // exp 200
    vecs[7]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1}; // exp 255 negative
    vecs[8]  = '{32'h3740_0000, 32'h0000_0001, 1'b0}; // 0.75 LSB
    vecs[9]  = '{32'h3700_0000, 32'h0000_0000, 1'b0}; // 0.5 LSB tie
    vecs[10] = '{32'h37C0_0000, 32'h0000_0002, 1'b0}; // 1.5 LSB tie
    vecs[11] = '{32'h2D00_0000, 32'h0000_0000, 1'b0}; // exp 90
    vecs[12] = '{32'hB680_0000, 32'h0000_0000, 1'b0}; // -0.25 LSB
    vecs[13] = '{32'h46FF_FFFF, 32'h7FFF_FF80, 1'b0}; // just below 2^15

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 33'(out_valid), 33'(0));
    check("reset_out_data", {out_sat, out_data}, 33'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    latency_check("lat_first", vecs[0].w, {vecs[0].sat, vecs[0].data});

    for (int i = 0; i < 14; i++) send(vecs[i].w, {vecs[i].sat, vecs[i].data});
    in_valid = 1'b0;
    drain();
    send(32'hB740_0000, {1'b0, 32'hFFFF_FFFF}); // -0.75 LSB
    in_valid = 1'b0;
    drain();

    // Backpressure: out_ready low for cycles 3-6 of a 6-sample burst.
    bp_phase  = 1'b1;
    saw_block = 1'b0;
    fork
      begin
        logic [31:0] w;
        for (int i = 0; i < 6; i++) begin
          w = rand_float();
          send(w, model(w));
        end
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    bp_phase = 1'b0;
    check("bp_in_ready_fell", 33'(saw_block), 33'(1));

    // Reset with two samples held in flight.
    out_ready = 1'b0;
    send(32'h3F80_0000, model(32'h3F80_0000));
    send(32'hC020_0000, model(32'hC020_0000));
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", 33'(out_valid), 33'(0));
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_ghost", 33'(out_valid), 33'(0));
    @(posedge clk);
    #1;
    latency_check("lat_after_rst", 32'h4040_0000, model(32'h4040_0000));

    // Randomized traffic with random downstream stalls.
    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = rand_float();
      send(w, model(w));
      if ($urandom % 5 == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rand_bp = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
